// File: rtl/mux_rr_select_arbiter.sv
// Round-robin packet-aware select for a 4:1 mux: grant/sel registered one cycle after req, held until an accepted last.
// out_valid = req[sel] while granted; out_ready only gates acceptance. Optional beat limit: RR_ARB_BEAT_LIMIT_EN.
module mux_rr_select_arbiter #(
  parameter int MAX_BEATS = 16,
  parameter int CNT_W     = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  input  logic [3:0] last,
  input  logic       out_ready,
  output logic [1:0] sel,
  output logic [3:0] grant,
  output logic       out_valid,
  output logic       beat_fire,
  output logic       busy,
  output logic       preempt
);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t     state_q, state_d;
  logic [1:0] sel_q, sel_d;
  logic [1:0] ptr_q, ptr_d;
  logic [3:0] grant_q, grant_d;
  logic [1:0] pick;
  logic       found;
  logic       release_pkt;
  logic       limit_hit;

  // First requester at or after ptr, wrapping modulo 4.
  always_comb begin
    pick  = ptr_q;
    found = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (!found && req[ptr_q + 2'(k)]) begin
        pick  = ptr_q + 2'(k);
        found = 1'b1;
      end
    end
  end

  assign busy        = (state_q == GRANT);
  // Gated by rst so nothing is accepted in a reset cycle.
  assign out_valid   = busy && req[sel_q] && !rst;
  assign beat_fire   = out_valid && out_ready;
  assign release_pkt = beat_fire && (last[sel_q] || limit_hit);

  assign sel   = sel_q;
  assign grant = grant_q;

`ifdef RR_ARB_BEAT_LIMIT_EN
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W:0]   cnt_inc;
  logic             preempt_q;

  // One extra bit so MAX_BEATS == 2^CNT_W is still reachable.
  assign cnt_inc   = {1'b0, cnt_q} + (CNT_W+1)'(1);
  assign limit_hit = (cnt_inc == (CNT_W+1)'(MAX_BEATS));
  assign preempt   = preempt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q     <= '0;
      preempt_q <= 1'b0;
    end else begin
      preempt_q <= beat_fire && !last[sel_q] && limit_hit;
      if (release_pkt)
        cnt_q <= '0;
      else if (beat_fire)
        cnt_q <= cnt_inc[CNT_W-1:0];
    end
  end
`else
  assign limit_hit = 1'b0;
  assign preempt   = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    grant_d = grant_q;
    ptr_d   = ptr_q;
    case (state_q)
      IDLE: begin
        if (found) begin
          state_d = GRANT;
          sel_d   = pick;
          grant_d = 4'b0001 << pick;
        end
      end
      GRANT: begin
        if (release_pkt) begin
          state_d = IDLE;
          grant_d = 4'b0000;
          ptr_d   = sel_q + 2'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sel_q   <= 2'b00;
      grant_q <= 4'b0000;
      ptr_q   <= 2'b00;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      grant_q <= grant_d;
      ptr_q   <= ptr_d;
    end
  end

endmodule

// File: tb/tb_mux_rr_select_arbiter.sv
// Directed and random checks of mux_rr_select_arbiter against a packet-level owner/pointer model.
module tb_mux_rr_select_arbiter;

  localparam int TB_MAX = 4;
`ifdef RR_ARB_BEAT_LIMIT_EN
  localparam bit LIMIT = 1'b1;
`else
  localparam bit LIMIT = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req;
  logic [3:0] last;
  logic       out_ready;
  logic [1:0] sel;
  logic [3:0] grant;
  logic       out_valid;
  logic       beat_fire;
  logic       busy;
  logic       preempt;

  int checks = 0;
  int errors = 0;
  int fires  = 0;

  // Model: current packet owner (-1 when idle), last selected index, search start, beats in this grant.
  int m_owner;
  int m_sel;
  int m_ptr;
  int m_beats;
  bit m_pre;

  always #5 clk = ~clk;

  mux_rr_select_arbiter #(.MAX_BEATS(TB_MAX), .CNT_W(5)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .last      (last),
    .out_ready (out_ready),
    .sel       (sel),
    .grant     (grant),
    .out_valid (out_valid),
    .beat_fire (beat_fire),
    .busy      (busy),
    .preempt   (preempt)
  );

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_check();
    bit exp_ov;
    exp_ov = (m_owner >= 0) && !rst && req[m_owner[1:0]];
    check("busy", 8'(busy), 8'(m_owner >= 0));
    check("grant", 8'(grant), (m_owner >= 0) ? 8'(1 << m_owner) : 8'h00);
    check("sel", 8'(sel), 8'(m_sel));
    check("out_valid", 8'(out_valid), 8'(exp_ov));
    check("beat_fire", 8'(beat_fire), 8'(exp_ov && out_ready));
    check("preempt", 8'(preempt), 8'(m_pre));
  endtask

  task automatic model_edge();
    bit fire;
    int idx;
    fire = (m_owner >= 0) && !rst && req[m_owner[1:0]] && out_ready;
    if (rst) begin
      m_owner = -1; m_sel = 0; m_ptr = 0; m_beats = 0; m_pre = 0;
    end else begin
      m_pre = 0;
      if (m_owner < 0) begin
        for (int k = 0; k < 4; k++) begin
          idx = (m_ptr + k) % 4;
          if (m_owner < 0 && req[idx[1:0]]) begin
            m_owner = idx;
            m_sel   = idx;
          end
        end
      end else if (fire) begin
        m_beats++;
        if (last[m_owner[1:0]] || (LIMIT && m_beats == TB_MAX)) begin
          m_pre   = LIMIT && !last[m_owner[1:0]];
          m_ptr   = (m_owner + 1) % 4;
          m_owner = -1;
          m_beats = 0;
        end
      end
    end
  endtask

  // Inputs change 1 time unit after a rising edge; outputs are checked 1 unit later.
  task automatic step(input logic r, input logic [3:0] q, input logic [3:0] l, input logic o);
    rst = r; req = q; last = l; out_ready = o;
    #1;
    model_check();
    if (beat_fire === 1'b1) fires++;
    model_edge();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [1:0] seq_q[$];
    logic [1:0] exp_seq [5];
    logic       prev_busy;
    logic [3:0] l;

    rst = 1'b1; req = 4'b0000; last = 4'b0000; out_ready = 1'b0;
    m_owner = -1; m_sel = 0; m_ptr = 0; m_beats = 0; m_pre = 0;
    @(posedge clk);
    #1;

    // Reset values
    step(1'b1, 4'b0000, 4'b0000, 1'b0);
    check("rst_grant", 8'(grant), 8'h00);
    check("rst_sel", 8'(sel), 8'h00);
    check("rst_busy", 8'(busy), 8'h00);

    // Single requester 2, one-beat packet, then search resumes at 3
    step(1'b0, 4'b0100, 4'b0100, 1'b1);
    check("t1_grant", 8'(grant), 8'h04);
    check("t1_sel", 8'(sel), 8'h02);
    fires = 0;
    step(1'b0, 4'b0100, 4'b0100, 1'b1);
    check("t1_fires", 8'(fires), 8'd1);
    check("t1_release_grant", 8'(grant), 8'h00);
    check("t1_release_busy", 8'(busy), 8'h00);
    step(1'b0, 4'b1001, 4'b0000, 1'b0);
    check("t1_next_sel", 8'(sel), 8'h03);
    step(1'b0, 4'b1001, 4'b1001, 1'b1);

    // All requesting, two-beat packets: 0,1,2,3,0 with one idle cycle between
    step(1'b1, 4'b0000, 4'b0000, 1'b0);
    exp_seq = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    prev_busy = 1'b0;
    for (int c = 0; c < 15; c++) begin
      l = (m_owner >= 0 && m_beats == 1) ? 4'b1111 : 4'b0000;
      step(1'b0, 4'b1111, l, 1'b1);
      if (busy && !prev_busy) seq_q.push_back(sel);
      prev_busy = busy;
    end
    check("t2_grant_count", 8'(seq_q.size()), 8'd5);
    for (int i = 0; i < 5; i++)
      if (i < seq_q.size()) check("t2_order", 8'(seq_q[i]), 8'(exp_seq[i]));

    // Requester 1, three beats, out_ready toggling
    step(1'b1, 4'b0000, 4'b0000, 1'b0);
    step(1'b0, 4'b0010, 4'b0000, 1'b0);
    fires = 0;
    for (int c = 0; c < 5; c++) begin
      check("t3_grant_held", 8'(grant), 8'h02);
      l = (m_beats == 2) ? 4'b0010 : 4'b0000;
      step(1'b0, 4'b0010, l, (c % 2 == 0));
    end
    check("t3_fires", 8'(fires), 8'd3);
    check("t3_released", 8'(grant), 8'h00);

    // Requester 3 drops req mid-packet, then finishes; next grant wraps to 0
    step(1'b1, 4'b0000, 4'b0000, 1'b0);
    step(1'b0, 4'b1000, 4'b0000, 1'b1);
    step(1'b0, 4'b1000, 4'b0000, 1'b1);
    for (int c = 0; c < 4; c++) begin
      step(1'b0, 4'b0000, 4'b0000, 1'b1);
      check("t4_grant_held", 8'(grant), 8'h08);
      check("t4_out_valid", 8'(out_valid), 8'h00);
    end
    step(1'b0, 4'b1000, 4'b1000, 1'b1);
    check("t4_released", 8'(grant), 8'h00);
    step(1'b0, 4'b1001, 4'b0000, 1'b0);
    check("t4_wrap_sel", 8'(sel), 8'h00);
    check("t4_wrap_grant", 8'(grant), 8'h01);
    step(1'b0, 4'b1001, 4'b1001, 1'b1);

    // Reset during second beat of requester 2
    step(1'b1, 4'b0000, 4'b0000, 1'b0);
    step(1'b0, 4'b0100, 4'b0000, 1'b1);
    step(1'b0, 4'b0100, 4'b0000, 1'b1);
    fires = 0;
    step(1'b1, 4'b0100, 4'b0000, 1'b1);
    check("t5_no_fire_in_rst", 8'(fires), 8'd0);
    check("t5_grant", 8'(grant), 8'h00);
    check("t5_sel", 8'(sel), 8'h00);
    check("t5_busy", 8'(busy), 8'h00);
    check("t5_out_valid", 8'(out_valid), 8'h00);
    step(1'b0, 4'b0110, 4'b0000, 1'b0);
    check("t5_ptr0_sel", 8'(sel), 8'h01);
    step(1'b0, 4'b0010, 4'b0010, 1'b1);

`ifdef RR_ARB_BEAT_LIMIT_EN
    // Beat limit forces release of a packet with no last
    step(1'b1, 4'b0000, 4'b0000, 1'b0);
    step(1'b0, 4'b0001, 4'b0000, 1'b1);
    fires = 0;
    for (int c = 0; c < TB_MAX; c++) step(1'b0, 4'b0001, 4'b0000, 1'b1);
    check("t6_fires", 8'(fires), 8'(TB_MAX));
    check("t6_preempt", 8'(preempt), 8'h01);
    check("t6_grant", 8'(grant), 8'h00);
    step(1'b0, 4'b0011, 4'b0000, 1'b0);
    check("t6_preempt_pulse", 8'(preempt), 8'h00);
    check("t6_next_grant", 8'(grant), 8'h02);
    step(1'b0, 4'b0011, 4'b0010, 1'b1);
`endif

    // Random traffic against the model
    step(1'b1, 4'b0000, 4'b0000, 1'b0);
    for (int c = 0; c < 600; c++) begin
      step(($urandom_range(0, 79) == 0),
           4'($urandom_range(0, 15)),
           ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'b0000,
           1'($urandom_range(0, 1)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
